// File: rtl/bash_f_iter_pkg.sv
// ---------------------------------------------------------------------------
// bash_f_iter_pkg
//
// Shared constants and helpers for the bash-f permutation:
//   - round count, first round constant and the constant-update polynomial
//   - bash-s rotation parameters (M1/N1/M2/N2) for the 8 columns
//   - the fixed word permutation applied after the bash-s layer
//   - FSM state encoding used by the iterative driver
//   - combinational helpers: 64-bit rotate, constant update, bash-s column
//
// State packing used throughout: word 0 sits in bits [1535:1472] and
// word 23 in bits [63:0].
// ---------------------------------------------------------------------------
package bash_f_iter_pkg;

    localparam int BASH_ROUNDS  = 24;
    localparam int BASH_W       = 64;
    localparam int BASH_NWORDS  = 24;
    localparam int BASH_STATE_W = BASH_W * BASH_NWORDS;

    // First round constant and the feedback polynomial of the constant LFSR.
    localparam logic [63:0] BASH_C1    = 64'hB194BAC80A08F53B;
    localparam logic [63:0] BASH_CPOLY = 64'hDC2BE1997FE0D8AE;

    // bash-s rotation amounts, one entry per column 0..7.
    localparam int BASH_M1 [8] = '{ 8, 56,  8, 56,  8, 56,  8, 56};
    localparam int BASH_N1 [8] = '{53, 51, 37,  3, 21, 19,  5, 35};
    localparam int BASH_M2 [8] = '{14, 34, 46,  2, 14, 34, 46,  2};
    localparam int BASH_N2 [8] = '{ 1,  7, 49, 23, 33, 39, 17, 55};

    // Output word k of a round is taken from input word BASH_PERM[k].
    localparam int BASH_PERM [24] = '{15, 10,  9, 12, 11, 14, 13,  8,
                                      17, 16, 19, 18, 21, 20, 23, 22,
                                       6,  3,  0,  5,  2,  7,  4,  1};

    // Driver FSM states.
    typedef enum logic [1:0] {
        BASH_IDLE = 2'd0,
        BASH_RUN  = 2'd1,
        BASH_DONE = 2'd2
    } bash_fsm_e;

    typedef logic [BASH_W-1:0] bash_word_t;

    // One bash-s column: the three words (w[i], w[i+8], w[i+16]).
    typedef struct packed {
        bash_word_t w0;
        bash_word_t w1;
        bash_word_t w2;
    } bash_col_t;

    // Rotate toward the high bits. Amounts are always in 1..63 here.
    function automatic bash_word_t bash_rotl(input bash_word_t x, input int n);
        return (x << n) | (x >> (BASH_W - n));
    endfunction

    // Round-constant update: Galois-style LFSR stepping to the right.
    function automatic bash_word_t bash_next_c(input bash_word_t c);
        return (c >> 1) ^ (c[0] ? BASH_CPOLY : '0);
    endfunction

    // bash-s S-box layer for one column.
    function automatic bash_col_t bash_s(input bash_col_t col_i,
                                         input int m1, input int n1,
                                         input int m2, input int n2);
        bash_word_t w0;
        bash_word_t w1;
        bash_word_t w2;
        bash_word_t t0;
        bash_word_t t1;
        bash_word_t t2;
        bash_col_t  col_o;

        w0 = col_i.w0;
        w1 = col_i.w1;
        w2 = col_i.w2;

        // Linear mixing part.
        t0 = bash_rotl(w0, m1);
        w0 = w0 ^ w1 ^ w2;
        t1 = w1 ^ bash_rotl(w0, n1);
        w1 = t0 ^ t1;
        w2 = w2 ^ bash_rotl(w2, m2) ^ bash_rotl(t1, n2);

        // Nonlinear part (NOT/OR/AND network).
        t0 = ~w2;
        t1 = w0 | w2;
        t2 = w0 & w1;
        t0 = t0 | w1;
        w1 = w1 ^ t1;
        w2 = w2 ^ t2;
        w0 = w0 ^ t0;

        col_o.w0 = w0;
        col_o.w1 = w1;
        col_o.w2 = w2;
        return col_o;
    endfunction

endpackage

// File: rtl/bash_f_round.sv
// ---------------------------------------------------------------------------
// bash_f_round
//
// One purely combinational bash-f round:
//   1. 8 bash-s columns over (w[i], w[i+8], w[i+16]), i = 0..7
//   2. fixed word permutation
//   3. round constant XORed into the last output word
//
// Ports:
//   state_i  [1535:0]  input state (word 0 in the top 64 bits)
//   c_i      [63:0]    round constant for this round
//   state_o  [1535:0]  output state, same packing
// ---------------------------------------------------------------------------
module bash_f_round
    import bash_f_iter_pkg::*;
(
    input  logic [BASH_STATE_W-1:0] state_i,
    input  logic [BASH_W-1:0]       c_i,
    output logic [BASH_STATE_W-1:0] state_o
);

    bash_word_t w_in  [BASH_NWORDS];
    bash_word_t w_mix [BASH_NWORDS];
    bash_word_t w_out [BASH_NWORDS];

    // Unpack the flat state into words.
    for (genvar gi = 0; gi < BASH_NWORDS; gi++) begin : g_unpack
        assign w_in[gi] = state_i[BASH_STATE_W-1-BASH_W*gi -: BASH_W];
    end

    // S-box layer: eight independent columns.
    for (genvar gi = 0; gi < 8; gi++) begin : g_col
        bash_col_t col_in;
        bash_col_t col_out;

        assign col_in  = {w_in[gi], w_in[gi+8], w_in[gi+16]};
        assign col_out = bash_s(col_in, BASH_M1[gi], BASH_N1[gi],
                                BASH_M2[gi], BASH_N2[gi]);

        assign w_mix[gi]    = col_out.w0;
        assign w_mix[gi+8]  = col_out.w1;
        assign w_mix[gi+16] = col_out.w2;
    end

    // Permutation; the last output word (sourced from word 1) absorbs the
    // round constant.
    for (genvar gi = 0; gi < BASH_NWORDS; gi++) begin : g_perm
        if (gi == BASH_NWORDS - 1) begin : g_const
            assign w_out[gi] = w_mix[BASH_PERM[gi]] ^ c_i;
        end else begin : g_plain
            assign w_out[gi] = w_mix[BASH_PERM[gi]];
        end
        assign state_o[BASH_STATE_W-1-BASH_W*gi -: BASH_W] = w_out[gi];
    end

endmodule

// File: rtl/bash_f_iter.sv
// ---------------------------------------------------------------------------
// bash_f_iter
//
// Iterative bash-f driver: accepts one 1536-bit state, runs ROUNDS rounds
// (one per clock) through a single bash_f_round instance, and presents the
// permuted state until the consumer takes it.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   in_data holds a state to permute
//   in_ready   high only in IDLE
//   in_data    input state (word 0 in [1535:1472], word 23 in [63:0])
//   out_valid  high only in DONE
//   out_ready  consumer takes out_data
//   out_data   permuted state, held stable while out_valid is high
//
// Timing: accept on edge k -> out_valid after edge k+ROUNDS. DONE always
// returns to IDLE before the next accept, so back-to-back blocks are spaced
// ROUNDS+2 cycles apart.
// ---------------------------------------------------------------------------
module bash_f_iter
    import bash_f_iter_pkg::*;
#(
    parameter int ROUNDS = BASH_ROUNDS
)
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BASH_STATE_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BASH_STATE_W-1:0] out_data
);

    localparam logic [1:0] IDLE = BASH_IDLE;
    localparam logic [1:0] RUN  = BASH_RUN;
    localparam logic [1:0] DONE = BASH_DONE;

    localparam logic [4:0] RND_LAST = 5'(ROUNDS - 1);

    logic [1:0]              state_q, state_d;
    logic [BASH_STATE_W-1:0] st_q, st_d;
    logic [BASH_W-1:0]       cst_q, cst_d;
    logic [4:0]              rnd_q, rnd_d;

    logic [BASH_STATE_W-1:0] round_out;

    bash_f_round u_round (
        .state_i (st_q),
        .c_i     (cst_q),
        .state_o (round_out)
    );

    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        cst_d   = cst_q;
        rnd_d   = rnd_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    st_d    = in_data;
                    cst_d   = BASH_C1;
                    rnd_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                st_d  = round_out;
                cst_d = bash_next_c(cst_q);
                rnd_d = rnd_q + 5'd1;
                // The update in this cycle is the final round.
                if (rnd_q == RND_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            st_q    <= '0;
            cst_q   <= BASH_C1;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            cst_q   <= cst_d;
            rnd_q   <= rnd_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = st_q;

endmodule
